wgt_tile_loader: RTL and testbench

WGT_TILE_LOADER -- requirements
Module: wgt_tile_loader

---
 rtl/wgt_tile_loader.sv | 155 +++++++++++++++
 tb/tb_wgt_tile_loader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wgt_tile_loader.sv
// Double-buffered weight tile loader: pops TILE_WORDS words from the upstream
// weight buffer into a shadow bank and swaps it into the active bank on tile_req.
module wgt_tile_loader #(
  parameter int DATA_WIDTH = 1536,
  parameter int TILE_WORDS = 3,
  parameter int CNT_W      = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             op_start_i,
  input  logic                             end_conv_i,
  input  logic                             g_stall_i,
  input  logic                             wgt_empty_i,
  input  logic [DATA_WIDTH-1:0]            wgt_data_i,
  output logic                             wgt_read_o,
  input  logic                             tile_req_i,
  output logic                             wgt_load_o,
  output logic [DATA_WIDTH*TILE_WORDS-1:0] wgt_out_o,
  output logic                             tile_valid_o,
  output logic [CNT_W-1:0]                 tile_cnt_o
);

  localparam int WC_W  = (TILE_WORDS > 1) ? $clog2(TILE_WORDS) : 1;
  localparam int OUT_W = DATA_WIDTH * TILE_WORDS;
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(TILE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, REQ, CAP, FULL} state_e;

  state_e            state_q, state_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic              shadow_full_q, shadow_full_d;
  logic              tile_valid_q, tile_valid_d;
  logic              wgt_load_q, wgt_load_d;
  logic [CNT_W-1:0]  tile_cnt_q, tile_cnt_d;
  logic [OUT_W-1:0]  wgt_out_q, wgt_out_d;
  logic [OUT_W-1:0]  shadow_flat;

  logic pop;
  logic cap;
  logic swap;

  // end_conv wins over everything, so no pop, capture or swap may coincide with it
  assign pop  = (state_q == REQ) && !g_stall_i && !wgt_empty_i && !end_conv_i;
  assign cap  = (state_q == CAP) && !g_stall_i && !end_conv_i;
  assign swap = tile_req_i && shadow_full_q && !g_stall_i && !end_conv_i;

  generate
    for (genvar gi = 0; gi < TILE_WORDS; gi++) begin : g_shadow
      logic [DATA_WIDTH-1:0] word_q;
      logic                  wr_en;

      assign wr_en = cap && (word_cnt_q == WC_W'(gi));

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          word_q <= '0;
        end else if (wr_en) begin
          word_q <= wgt_data_i;
        end
      end

      assign shadow_flat[gi*DATA_WIDTH +: DATA_WIDTH] = word_q;
    end
  endgenerate

  always_comb begin
    state_d       = state_q;
    word_cnt_d    = word_cnt_q;
    shadow_full_d = shadow_full_q;
    tile_valid_d  = tile_valid_q;
    tile_cnt_d    = tile_cnt_q;
    wgt_load_d    = 1'b0;
    wgt_out_d     = wgt_out_q;

    if (end_conv_i) begin
      state_d       = IDLE;
      word_cnt_d    = '0;
      shadow_full_d = 1'b0;
      tile_valid_d  = 1'b0;
    end else if (!g_stall_i) begin
      case (state_q)
        IDLE: begin
          if (op_start_i) begin
            state_d    = REQ;
            tile_cnt_d = '0;
          end
        end
        REQ: begin
          if (pop) begin
            state_d = CAP;
          end
        end
        CAP: begin
          if (word_cnt_q == LAST_WORD) begin
            word_cnt_d    = '0;
            shadow_full_d = 1'b1;
            state_d       = FULL;
          end else begin
            word_cnt_d = word_cnt_q + WC_W'(1);
            state_d    = REQ;
          end
        end
        FULL: begin
          if (!shadow_full_q) begin
            state_d = REQ;
          end
        end
        default: state_d = IDLE;
      endcase

      // shadow_full is only ever set on the way into FULL, so a swap never
      // collides with the capture of the last word
      if (swap) begin
        wgt_out_d     = shadow_flat;
        shadow_full_d = 1'b0;
        tile_valid_d  = 1'b1;
        wgt_load_d    = 1'b1;
        tile_cnt_d    = tile_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      word_cnt_q    <= '0;
      shadow_full_q <= 1'b0;
      tile_valid_q  <= 1'b0;
      wgt_load_q    <= 1'b0;
      tile_cnt_q    <= '0;
      wgt_out_q     <= '0;
    end else begin
      state_q       <= state_d;
      word_cnt_q    <= word_cnt_d;
      shadow_full_q <= shadow_full_d;
      tile_valid_q  <= tile_valid_d;
      wgt_load_q    <= wgt_load_d;
      tile_cnt_q    <= tile_cnt_d;
      wgt_out_q     <= wgt_out_d;
    end
  end

  // Pop data arrives the cycle after wgt_read, so a pop can never be a stale repeat
  assign wgt_read_o   = pop;
  assign wgt_load_o   = wgt_load_q;
  assign wgt_out_o    = wgt_out_q;
  assign tile_valid_o = tile_valid_q;
  assign tile_cnt_o   = tile_cnt_q;

`ifndef SYNTHESIS
  a_no_back_to_back_read: assert property (
    @(posedge clk_i) disable iff (!rst_ni) wgt_read_o |=> !wgt_read_o);
`endif

endmodule

// File: tb/tb_wgt_tile_loader.sv
// Scoreboard bench for wgt_tile_loader: directed words from a queue-modelled
// upstream buffer, expected tiles queued at stimulus time and checked on wgt_load.
module tb_wgt_tile_loader;

  localparam int DW = 1536;
  localparam int TW = 3;
  localparam int CW = 16;
  localparam int OW = DW * TW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          op_start;
  logic          end_conv;
  logic          g_stall;
  logic          tile_req;
  logic [DW-1:0] wgt_data = '0;
  logic          wgt_empty;
  logic          wgt_read;
  logic          wgt_load;
  logic          tile_valid;
  logic [OW-1:0] wgt_out;
  logic [CW-1:0] tile_cnt;

  typedef struct {
    logic [OW-1:0] tile;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [DW-1:0] src_q[$];
  int            pushed = 0;
  int            popped = 0;
  int            cyc = 0;
  int            pops = 0;
  int            loads = 0;
  int            pop_cyc[$];
  int            n_chk = 0;
  int            n_pass = 0;
  logic          prev_rd = 1'b0;
  int            t0;
  int            p0;

  localparam logic [31:0] TA = 32'hAAAA0001, TB = 32'hBBBB0002, TC = 32'hCCCC0003;
  localparam logic [31:0] TD = 32'hDDDD0004, TE = 32'hEEEE0005, TF = 32'hFFFF0006;
  localparam logic [31:0] TG = 32'h11110007, TH = 32'h22220008, TI = 32'h33330009;
  localparam logic [31:0] TJ = 32'h4444000A, TK = 32'h5555000B, TL = 32'h6666000C;
  localparam logic [31:0] TM = 32'h7777000D, TN = 32'h8888000E, TO = 32'h9999000F;
  localparam logic [31:0] TP = 32'h12340010, TQ = 32'h56780011, TR = 32'h9ABC0012;

  always #5 clk = ~clk;

  assign wgt_empty = (pushed == popped);

  wgt_tile_loader #(.DATA_WIDTH(DW), .TILE_WORDS(TW), .CNT_W(CW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .op_start_i   (op_start),
    .end_conv_i   (end_conv),
    .g_stall_i    (g_stall),
    .wgt_empty_i  (wgt_empty),
    .wgt_data_i   (wgt_data),
    .wgt_read_o   (wgt_read),
    .tile_req_i   (tile_req),
    .wgt_load_o   (wgt_load),
    .wgt_out_o    (wgt_out),
    .tile_valid_o (tile_valid),
    .tile_cnt_o   (tile_cnt)
  );

  function automatic logic [DW-1:0] mkw(input logic [31:0] tag);
    mkw = {48{tag}};
  endfunction

  function automatic logic [OW-1:0] mkt(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
    mkt = {mkw(c), mkw(b), mkw(a)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic chk_tile(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got words %h %h %h want %h %h %h", nm,
                  act[2*DW +: 32], act[DW +: 32], act[0 +: 32],
                  exp[2*DW +: 32], exp[DW +: 32], exp[0 +: 32]);
  endtask

  task automatic push(input logic [31:0] tag);
    src_q.push_back(mkw(tag));
    pushed++;
  endtask

  task automatic expect_tile(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c, input logic [CW-1:0] cnt);
    exp_t e;
    e.tile = mkt(a, b, c);
    e.cnt  = cnt;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_load(input int lim);
    int l0;
    l0 = loads;
    for (int i = 0; i < lim && loads == l0; i++) tick(1);
    if (loads == l0) begin
      n_chk++;
      $display("FAIL wait_load: got no wgt_load within %0d cycles want one", lim);
    end
  endtask

  // Upstream buffer model: registered pop, data valid the cycle after wgt_read
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && wgt_read) begin
      if (src_q.size() == 0) begin
        n_chk++;
        $display("FAIL over_pop: got wgt_read with empty buffer want no read");
      end else begin
        wgt_data <= src_q.pop_front();
        popped   <= popped + 1;
      end
    end
  end

  // Pop monitor
  always @(negedge clk) begin
    if (wgt_read) begin
      pops++;
      pop_cyc.push_back(cyc);
      chk("no_back_to_back_read", {63'd0, prev_rd}, 64'd0);
    end
    prev_rd = wgt_read;
  end

  // Tile scoreboard
  always @(negedge clk) begin
    if (wgt_load) begin
      loads++;
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_load: got load with tile_cnt %0d want no load", tile_cnt);
      end else begin
        mon_e = exp_q.pop_front();
        chk_tile("load_tile", wgt_out, mon_e.tile);
        chk("load_tile_cnt", {48'd0, tile_cnt}, {48'd0, mon_e.cnt});
        chk("load_tile_valid", {63'd0, tile_valid}, 64'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; op_start = 1'b0; end_conv = 1'b0; g_stall = 1'b0; tile_req = 1'b0;
    tick(3);
    chk("reset_wgt_read", {63'd0, wgt_read}, 64'd0);
    chk("reset_wgt_load", {63'd0, wgt_load}, 64'd0);
    chk("reset_tile_valid", {63'd0, tile_valid}, 64'd0);
    chk("reset_tile_cnt", {48'd0, tile_cnt}, 64'd0);
    chk_tile("reset_wgt_out", wgt_out, '0);
    rst_n = 1'b1;
    tick(2);

    // Basic load
    pop_cyc.delete();
    push(TA); push(TB); push(TC);
    expect_tile(TA, TB, TC, 16'd1);
    tile_req = 1'b1; op_start = 1'b1; t0 = cyc;
    tick(1);
    op_start = 1'b0;
    wait_load(40);
    tile_req = 1'b0;
    chk("basic_pop_count", pop_cyc.size(), 3);
    for (int i = 0; i < pop_cyc.size() && i < 3; i++)
      chk($sformatf("basic_pop%0d_cycle", i), pop_cyc[i] - t0, 2 * i + 1);

    // Underflow, then double buffering while tile 1 is active
    p0 = pops;
    tick(10);
    chk("underflow_no_read", pops - p0, 0);
    pop_cyc.delete();
    push(TD); t0 = cyc;
    tick(1);
    chk("first_pop_after_empty_cycle", (pop_cyc.size() > 0) ? pop_cyc[0] - t0 : -1, 0);
    push(TE); push(TF);
    tick(20);
    chk("full_pop_count", pops - p0, 3);
    chk("full_no_read", {63'd0, wgt_read}, 64'd0);
    chk_tile("full_active_kept", wgt_out, mkt(TA, TB, TC));
    chk("full_tile_cnt", {48'd0, tile_cnt}, 64'd1);
    expect_tile(TD, TE, TF, 16'd2);
    tile_req = 1'b1;
    wait_load(10);
    tile_req = 1'b0;

    // Global stall while capturing the second word
    push(TG);
    tick(6);
    push(TH);
    tick(1);
    g_stall = 1'b1; p0 = pops;
    tick(4);
    g_stall = 1'b0;
    chk("stall_cap_no_read", pops - p0, 0);
    chk_tile("stall_active_kept", wgt_out, mkt(TD, TE, TF));
    chk("stall_tile_cnt", {48'd0, tile_cnt}, 64'd2);
    chk("stall_tile_valid", {63'd0, tile_valid}, 64'd1);
    tick(2);
    g_stall = 1'b1; push(TI); p0 = pops;
    tick(3);
    chk("stall_req_no_read", pops - p0, 0);
    g_stall = 1'b0;
    expect_tile(TG, TH, TI, 16'd3);
    tile_req = 1'b1;
    wait_load(20);
    tile_req = 1'b0;

    // end_conv mid-tile, together with g_stall
    push(TJ); push(TK);
    tick(8);
    end_conv = 1'b1; g_stall = 1'b1;
    tick(1);
    end_conv = 1'b0; g_stall = 1'b0;
    push(TL);
    #1;
    chk("end_tile_valid", {63'd0, tile_valid}, 64'd0);
    chk("end_wgt_load", {63'd0, wgt_load}, 64'd0);
    chk("end_idle_no_read", {63'd0, wgt_read}, 64'd0);
    chk("end_tile_cnt_held", {48'd0, tile_cnt}, 64'd3);
    p0 = pops;
    tick(5);
    chk("idle_no_pop", pops - p0, 0);
    push(TM); push(TN);
    expect_tile(TL, TM, TN, 16'd1);
    op_start = 1'b1;
    tick(1);
    op_start = 1'b0;
    chk("op_start_clears_cnt", {48'd0, tile_cnt}, 64'd0);
    tile_req = 1'b1;
    wait_load(30);
    tile_req = 1'b0;

    // Asynchronous reset while FULL
    push(TO); push(TP); push(TQ);
    tick(15);
    chk("pre_reset_tile_valid", {63'd0, tile_valid}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_wgt_read", {63'd0, wgt_read}, 64'd0);
    chk("areset_wgt_load", {63'd0, wgt_load}, 64'd0);
    chk("areset_tile_valid", {63'd0, tile_valid}, 64'd0);
    chk("areset_tile_cnt", {48'd0, tile_cnt}, 64'd0);
    chk_tile("areset_wgt_out", wgt_out, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(TR); p0 = pops;
    tick(6);
    chk("post_reset_needs_op_start", pops - p0, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
